// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents:
//   idx_width()   index width for n items, never less than one bit
//   port_idx_t    port index at the default port count
//   mem_req_t     one master's request slice {we, addr, be, wdata} at default widths
//   lock_state_e  lock FSM state encoding
// The top level re-declares the index and request types with its own
// parameter values, so these typedefs are the default-width reference shapes.
package mem_arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NR_PORTS   = 2;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [idx_width(DEF_NR_PORTS)-1:0] port_idx_t;

    typedef struct packed {
        logic                          we;
        logic [DEF_ADDR_WIDTH-1:0]     addr;
        logic [DEF_DATA_WIDTH/8-1:0]   be;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
    } mem_req_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker, purely combinational.
// Ports:
//   eligible  in   N       requests allowed to compete this cycle
//   rr        in   IW      index with the highest priority
//   winner    out  IW      first eligible index at or after rr, wrapping
//   valid     out  1       at least one eligible request
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]              eligible,
    input  logic [idx_width(N)-1:0]   rr,
    output logic [idx_width(N)-1:0]   winner,
    output logic                      valid
);

    localparam int IW = idx_width(N);

    // The first loop finds the lowest eligible index overall (the wrapped
    // case); the second overrides it with the lowest eligible index at or
    // after rr when one exists. Descending loops make the lowest index win.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IW'(i);
                valid  = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i] && (i >= int'(rr))) begin
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM (1-cycle read latency, never stalls) between
// NR_PORTS masters with round-robin grants, a per-port lock for
// read-modify-write sequences, and a watchdog that breaks a stale lock.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/we_i/lock_i    per-port request, write enable, hold-grant-after
//   addr_i/be_i/wdata_i  per-port flattened slices, port k at slice k
//   gnt_o                one-hot grant, combinational, same cycle as request
//   rvalid_o             response strobe for the port granted last cycle
//   rdata_o              SRAM read data passed straight through
//   mem_*_o              SRAM request, driven from the winner (zero when idle)
//   mem_rdata_i          SRAM read data
//   lock_err_o           one-cycle pulse when the watchdog drops a lock
//
// Lock FSM:
//   state    | meaning
//   UNLOCKED | every requesting port competes round-robin
//   LOCKED   | only owner_q may be granted; watchdog counts owner idle cycles
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NR_PORTS        = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS-1:0]              req_i,
    input  logic [NR_PORTS-1:0]              we_i,
    input  logic [NR_PORTS-1:0]              lock_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NR_PORTS-1:0]              gnt_o,
    output logic [NR_PORTS-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]          mem_be_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
    output logic                             lock_err_o
);

    localparam int IW = idx_width(NR_PORTS);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = idx_width(MAX_LOCK_CYCLES);

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BW-1:0]         be;
        logic [DATA_WIDTH-1:0] wdata;
    } port_req_t;

    lock_state_e   state_q;
    idx_t          owner_q;
    idx_t          rr_q;
    idx_t          resp_id_q;
    cnt_t          lock_cnt_q;
    logic          resp_valid_q;
    logic          lock_err_q;

    port_req_t            port_req [NR_PORTS];
    port_req_t            sel;
    logic [NR_PORTS-1:0]  owner_mask;
    logic [NR_PORTS-1:0]  eligible;
    idx_t                 winner;
    logic                 pick_valid;

    function automatic idx_t rr_next(input idx_t i);
        if (int'(i) >= NR_PORTS - 1) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

    for (genvar k = 0; k < NR_PORTS; k++) begin : g_slice
        assign port_req[k] = '{
            we:    we_i[k],
            addr:  addr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
            be:    be_i[k*BW +: BW],
            wdata: wdata_i[k*DATA_WIDTH +: DATA_WIDTH]
        };
    end

    // While locked, everyone but the owner is held off without a grant.
    assign owner_mask = NR_PORTS'(1) << owner_q;
    assign eligible   = (state_q == LOCKED) ? (req_i & owner_mask) : req_i;

    rr_pick #(
        .N (NR_PORTS)
    ) u_rr_pick (
        .eligible (eligible),
        .rr       (rr_q),
        .winner   (winner),
        .valid    (pick_valid)
    );

    assign gnt_o = pick_valid ? (NR_PORTS'(1) << winner) : '0;
    assign sel   = pick_valid ? port_req[winner] : '0;

    assign mem_req_o   = pick_valid;
    assign mem_we_o    = sel.we;
    assign mem_addr_o  = sel.addr;
    assign mem_be_o    = sel.be;
    assign mem_wdata_o = sel.wdata;

    assign rvalid_o   = resp_valid_q ? (NR_PORTS'(1) << resp_id_q) : '0;
    assign rdata_o    = mem_rdata_i;
    assign lock_err_o = lock_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= UNLOCKED;
            owner_q      <= '0;
            rr_q         <= '0;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            lock_err_q   <= 1'b0;
        end else begin
            lock_err_q   <= 1'b0;
            resp_valid_q <= pick_valid;
            if (pick_valid) begin
                resp_id_q <= winner;
            end

            case (state_q)
                UNLOCKED: begin
                    if (pick_valid) begin
                        // A locking grant keeps rr_q so priority resumes
                        // where it was once the sequence finishes.
                        if (lock_i[winner]) begin
                            state_q    <= LOCKED;
                            owner_q    <= winner;
                            lock_cnt_q <= '0;
                        end else begin
                            rr_q <= rr_next(winner);
                        end
                    end
                end

                LOCKED: begin
                    // Any grant here is the owner's, including one in the
                    // watchdog's final cycle, which therefore beats the timeout.
                    if (pick_valid) begin
                        lock_cnt_q <= '0;
                        if (!lock_i[winner]) begin
                            state_q <= UNLOCKED;
                            rr_q    <= rr_next(winner);
                        end
                    end else if (lock_cnt_q == cnt_t'(MAX_LOCK_CYCLES - 1)) begin
                        state_q    <= UNLOCKED;
                        lock_cnt_q <= '0;
                        rr_q       <= rr_next(owner_q);
                        lock_err_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + cnt_t'(1);
                    end
                end

                default: begin
                    state_q <= UNLOCKED;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port SRAM (1-cycle read latency, always ready) between NR_PORTS memory-request masters, e.g. several AXI-to-SRAM adapters or a DMA plus an adapter. Grants are round-robin. A per-port lock keeps the grant with one master across a read-modify-write sequence, so no other master can slip between the read and the write-back. A watchdog releases a stale lock and flags an error.

Parameters:
NR_PORTS, 2, number of requesting masters (>=1)
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, memory data width; byte enables are DATA_WIDTH/8
MAX_LOCK_CYCLES, 16, consecutive locked cycles with no owner request before forced release (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NR_PORTS  per-port request valid
we_i  in  NR_PORTS  per-port write enable
lock_i  in  NR_PORTS  hold grant after this request (RMW in progress)
addr_i  in  NR_PORTS*ADDR_WIDTH  per-port address, port k at slice k
be_i  in  NR_PORTS*DATA_WIDTH/8  per-port byte enables
wdata_i  in  NR_PORTS*DATA_WIDTH  per-port write data
gnt_o  out  NR_PORTS  one-hot grant, same cycle as request
rvalid_o  out  NR_PORTS  response valid, one cycle after grant
rdata_o  out  DATA_WIDTH  read data, shared by all ports
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  ADDR_WIDTH  SRAM address
mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after mem_req_o
lock_err_o  out  1  one-cycle pulse on watchdog lock release

Behaviour:
- Reset: rr_q=0, locked_q=0, owner_q=0, lock_cnt_q=0, resp_valid_q=0, resp_id_q=0.
- Reset state of outputs: gnt_o=0, rvalid_o=0, mem_req_o=0, lock_err_o=0. mem_* data and address outputs are 0 when mem_req_o=0.
- Eligible set:
  - Unlocked: all req_i.
  - Locked: only req_i[owner_q].
- Winner selection:
  - First eligible index at or after rr_q, wrapping modulo NR_PORTS.
  - gnt_o = onehot(winner). It is purely combinational from req_i and state, with no bubble.
- mem_req_o = |eligible. mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o come from the winner's slice.
- The SRAM never stalls. A granted request is complete in that cycle. The master must drop or change its request on the next cycle.
- Response path:
  - On any grant: resp_valid_q<=1, resp_id_q<=winner.
  - Otherwise resp_valid_q<=0.
  - rvalid_o[resp_id_q]=resp_valid_q. Both reads and writes get a response.
  - rdata_o = mem_rdata_i, combinational. Content is undefined for writes.
- Round-robin pointer: on a grant with lock_i[winner]=0, rr_q<=(winner+1) mod NR_PORTS. A locked grant leaves rr_q unchanged.
- Lock acquire: granted with lock_i[winner]=1 and locked_q=0 -> locked_q<=1, owner_q<=winner, lock_cnt_q<=0.
- Lock hold: granted owner with lock_i=1 -> stay locked, lock_cnt_q<=0.
- Lock release:
  - Granted owner with lock_i=0 -> locked_q<=0.
  - rr_q advances past the owner, as for any unlocked grant.
- Watchdog:
  - While locked_q=1 and the owner does not request, lock_cnt_q increments each cycle.
  - When lock_cnt_q==MAX_LOCK_CYCLES-1, that cycle's next edge clears locked_q and lock_cnt_q, advances rr_q to owner+1, and pulses lock_err_o for one cycle (registered).
  - Other ports may win from the following cycle.
- Simultaneous events:
  - An owner request in the watchdog's final cycle wins: it is granted and resets the counter, and no error is raised.
  - Other ports' requests while locked are held off (gnt_o=0). They must keep req_i asserted.
- NR_PORTS=1: the index width is max(1,$clog2(NR_PORTS)), rr_q stays 0, and the lock only affects the watchdog.
- Reset mid-operation: a pending response is dropped (no rvalid_o), and any lock is cleared.

Decomposition:
- Package mem_arb_pkg holds:
  - Localparam function idx_width(n) = max(1,$clog2(n)).
  - Typedef for the port index.
  - Typedef mem_req_t {we, addr, be, wdata}, parameterised via the module's localparams.
- One sub-module, rr_pick. It is combinational: from the eligible vector and rr_q it produces the winner index and a valid flag.
- The top level holds the lock FSM (UNLOCKED/LOCKED), the watchdog counter, the response register and the output mux.

Test Plan:
- Fairness, NR_PORTS=2: both ports request continuously -> grants alternate 0,1,0,1. rvalid_o follows each grant one cycle later with the matching bit. mem_addr_o equals the granted port's address.
- Basic read: port0 reads 0x10 after port0 has written 0xDEADBEEF to 0x10 with be=4'hF -> rvalid_o=2'b01 the next cycle and rdata_o=0xDEADBEEF.
- Locked RMW, NR_PORTS=2: port1 reads 0x20 with lock=1, then writes 0x20 with lock=0 three cycles later, while port0 requests continuously -> gnt_o[0]=0 throughout the lock. Port0 is granted in the cycle after the write. lock_err_o stays 0.
- Watchdog, MAX_LOCK_CYCLES=4: port0 takes the lock and then goes idle; port1 requests -> lock_err_o pulses once, port1 is granted 5 cycles after the lock grant, and rr_q=1.
- Watchdog edge: the owner requests in the 4th idle cycle -> owner is granted, no lock_err_o, and the lock is retained.
- Reset: assert rst_ni low the cycle after a grant -> no rvalid_o, and the lock is cleared. After release, the first simultaneous request from both ports is granted to port0.
